// File: rtl/gt_player_pkg.sv
// rtl/gt_player_pkg.sv - shared mode/state types and PRBS-31 constants for gt_pattern_player
package gt_player_pkg;

  typedef enum logic [1:0] {
    MODE_ONESHOT = 2'd0,
    MODE_CONT    = 2'd1,
    MODE_REPEAT  = 2'd2,
    MODE_PRBS    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // x^31 + x^28 + 1: feedback taps are state bits 30 and 27
  localparam int          PRBS31_TAP_A = 30;
  localparam int          PRBS31_TAP_B = 27;
  localparam logic [30:0] PRBS31_SEED  = 31'h1;

endpackage

// File: rtl/gt_pattern_ram.sv
// rtl/gt_pattern_ram.sv - per-channel pattern RAM, 1 write / 1 registered read port, read-first
module gt_pattern_ram
  import gt_player_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  // Read and write share one edge; the read samples the word before the write lands.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/gt_pattern_player.sv
// rtl/gt_pattern_player.sv - multi-channel GT TX pattern playback engine
// GT_PLAYER_PRBS_EN adds per-channel PRBS-31 generators for mode 3.
module gt_pattern_player
  import gt_player_pkg::*;
#(
  parameter  int CHN_NUM = 6,
  parameter  int DATA_W  = 32,
  parameter  int DEPTH   = 1024,
  localparam int ADDR_W  = $clog2(DEPTH),
  localparam int IDX_W   = (CHN_NUM > 1) ? $clog2(CHN_NUM) : 1
) (
  input  logic                      gt_clk,
  input  logic                      gt_rstb,
  input  logic                      ram_we,
  input  logic [IDX_W-1:0]          ram_idx,
  input  logic [ADDR_W-1:0]         ram_addr,
  input  logic [DATA_W-1:0]         ram_data,
  input  logic                      reg_start,
  input  logic                      reg_stop,
  input  logic [1:0]                reg_mode,
  input  logic [ADDR_W-1:0]         reg_len,
  input  logic [15:0]               reg_repeat,
  input  logic [CHN_NUM-1:0]        chn_en,
  output logic [CHN_NUM*DATA_W-1:0] gt_data,
  output logic                      gt_valid,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               loop_cnt
);

  state_e                    state_q, state_d;
  mode_e                     mode_q, mode_d;
  logic [ADDR_W-1:0]         len_q, len_d, addr_q, addr_d;
  logic [15:0]               rep_q, rep_d, loop_q, loop_d;
  logic [CHN_NUM-1:0]        en_q, en_d;
  logic                      drain_q, drain_d;
  logic                      rd_vld_q, rd_vld_d;
  logic                      gt_valid_q, gt_valid_d;
  logic                      done_q, done_d;
  logic [CHN_NUM*DATA_W-1:0] gt_data_q, gt_data_d;

  logic              mode_ok, start_ok, stop_hit, last_addr, pass_last, final_word;
  logic [DATA_W-1:0] ram_rd   [CHN_NUM];
  logic [DATA_W-1:0] src_word [CHN_NUM];

`ifdef GT_PLAYER_PRBS_EN
  assign mode_ok = 1'b1;
`else
  assign mode_ok = (mode_e'(reg_mode) != MODE_PRBS);
`endif

  assign start_ok   = reg_start && !reg_stop && mode_ok;
  assign stop_hit   = reg_stop && (state_q != ST_IDLE);
  assign last_addr  = (addr_q == len_q);
  assign pass_last  = ((loop_q + 16'd1) == rep_q);
  assign final_word = last_addr && ((mode_q == MODE_ONESHOT) ||
                                    ((mode_q == MODE_REPEAT) && pass_last));

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start_ok) state_d = ST_RUN;
      ST_RUN: begin
        if (reg_stop)        state_d = ST_IDLE;
        else if (final_word) state_d = ST_DRAIN;
      end
      ST_DRAIN: if (reg_stop || drain_q) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mode_d   = mode_q;
    len_d    = len_q;
    rep_d    = rep_q;
    en_d     = en_q;
    addr_d   = '0;
    loop_d   = loop_q;
    drain_d  = 1'b0;
    rd_vld_d = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          mode_d = mode_e'(reg_mode);
          len_d  = reg_len;
          rep_d  = (reg_repeat == 16'd0) ? 16'd1 : reg_repeat;
          en_d   = chn_en;
          loop_d = '0;
        end
      end
      ST_RUN: begin
        if (!reg_stop) begin
          rd_vld_d = 1'b1;
          addr_d   = last_addr ? '0 : addr_q + ADDR_W'(1);
          if (last_addr && (mode_q != MODE_PRBS) && (loop_q != 16'hFFFF)) begin
            loop_d = loop_q + 16'd1;
          end
        end
      end
      ST_DRAIN: begin
        drain_d = !drain_q && !reg_stop;
        done_d  = drain_q && !reg_stop;
      end
      default: ;
    endcase
    // A stop flushes the word already read so nothing leaks out after it.
    gt_valid_d = rd_vld_q && !stop_hit;
    gt_data_d  = '0;
    for (int c = 0; c < CHN_NUM; c++) begin
      if (gt_valid_d && en_q[c]) gt_data_d[c*DATA_W +: DATA_W] = src_word[c];
    end
  end

  always_ff @(posedge gt_clk or negedge gt_rstb) begin
    if (!gt_rstb) begin
      mode_q     <= MODE_ONESHOT;
      len_q      <= '0;
      rep_q      <= '0;
      en_q       <= '0;
      addr_q     <= '0;
      loop_q     <= '0;
      drain_q    <= 1'b0;
      rd_vld_q   <= 1'b0;
      gt_valid_q <= 1'b0;
      done_q     <= 1'b0;
      gt_data_q  <= '0;
    end else begin
      mode_q     <= mode_d;
      len_q      <= len_d;
      rep_q      <= rep_d;
      en_q       <= en_d;
      addr_q     <= addr_d;
      loop_q     <= loop_d;
      drain_q    <= drain_d;
      rd_vld_q   <= rd_vld_d;
      gt_valid_q <= gt_valid_d;
      done_q     <= done_d;
      gt_data_q  <= gt_data_d;
    end
  end

  for (genvar c = 0; c < CHN_NUM; c++) begin : g_chn
    localparam logic [IDX_W-1:0] CHN_IDX = IDX_W'(c);

    gt_pattern_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
    ) u_ram (
      .clk     (gt_clk),
      .wr_en   (ram_we && (ram_idx == CHN_IDX)),
      .wr_addr (ram_addr),
      .wr_data (ram_data),
      .rd_addr (addr_q),
      .rd_data (ram_rd[c])
    );

`ifdef GT_PLAYER_PRBS_EN
    logic [30:0]       prbs_st_q, prbs_st_d, prbs_nx;
    logic [DATA_W-1:0] prbs_word_q, prbs_word_d, prbs_gen;

    // The word register sits where the RAM read register does, so latency matches.
    always_comb begin
      prbs_nx  = prbs_st_q;
      prbs_gen = '0;
      for (int b = DATA_W - 1; b >= 0; b--) begin
        prbs_gen[b] = prbs_nx[PRBS31_TAP_A] ^ prbs_nx[PRBS31_TAP_B];
        prbs_nx     = {prbs_nx[29:0], prbs_gen[b]};
      end
      prbs_st_d   = prbs_st_q;
      prbs_word_d = prbs_word_q;
      if ((state_q == ST_IDLE) && start_ok) begin
        prbs_st_d = PRBS31_SEED << c;
      end else if ((state_q == ST_RUN) && !reg_stop) begin
        prbs_st_d   = prbs_nx;
        prbs_word_d = prbs_gen;
      end
    end

    always_ff @(posedge gt_clk or negedge gt_rstb) begin
      if (!gt_rstb) begin
        prbs_st_q   <= '0;
        prbs_word_q <= '0;
      end else begin
        prbs_st_q   <= prbs_st_d;
        prbs_word_q <= prbs_word_d;
      end
    end

    assign src_word[c] = (mode_q == MODE_PRBS) ? prbs_word_q : ram_rd[c];
`else
    assign src_word[c] = ram_rd[c];
`endif
  end

  assign gt_data  = gt_data_q;
  assign gt_valid = gt_valid_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign loop_cnt = loop_q;

endmodule
